// File: rtl/encoder_pkg.sv
// Shared types and constants for the four-to-two request encoder.
package encoder_pkg;

    localparam int N_REQ  = 4;
    localparam int CODE_W = 2;

    // IDLE: nothing presented | PRESENT: code/valid held until ack
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // One-hot mask selecting the request line addressed by idx.
    function automatic logic [N_REQ-1:0] one_hot(input logic [CODE_W-1:0] idx);
        logic [N_REQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/four_to_two_priority_encoder.sv
// Combinational fixed-priority encoder, bit 3 highest.
module four_to_two_priority_encoder
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0]  in_vec,
    output logic [CODE_W-1:0] code,
    output logic              nonzero
);

    // Highest set bit wins; all-zero input reports nonzero = 0 and code 0.
    always_comb begin
        code    = 2'd0;
        nonzero = 1'b1;
        if (in_vec[3]) begin
            code = 2'd3;
        end else if (in_vec[2]) begin
            code = 2'd2;
        end else if (in_vec[1]) begin
            code = 2'd1;
        end else if (in_vec[0]) begin
            code = 2'd0;
        end else begin
            nonzero = 1'b0;
        end
    end

endmodule

// File: rtl/four_to_two_request_encoder.sv
// Latches request lines as pending and presents the highest-priority one
// as a binary code with a valid/ack handshake. No preemption while presenting.
module four_to_two_request_encoder
    import encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [N_REQ-1:0]  pending,
    output logic              any_pending
);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              any_pending_q, any_pending_d;
    logic [N_REQ-1:0]  clr_mask;
    logic [CODE_W-1:0] enc_code;
    logic              enc_nonzero;

    four_to_two_priority_encoder u_prio (
        .in_vec  (pending_q),
        .code    (enc_code),
        .nonzero (enc_nonzero)
    );

    // Handshake FSM plus pending update; a same-edge re-request beats the ack clear.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        valid_d  = valid_q;
        clr_mask = '0;
        case (state_q)
            IDLE: begin
                if (enc_nonzero) begin
                    code_d  = enc_code;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end else begin
                    valid_d = 1'b0;
                end
            end
            PRESENT: begin
                if (ack) begin
                    clr_mask = one_hot(code_q);
                    valid_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        pending_d     = (pending_q & ~clr_mask) | (en ? req : '0);
        any_pending_d = |pending_d;
    end

    // State and output registers; reset discards any in-flight presentation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            code_q        <= '0;
            valid_q       <= 1'b0;
            any_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            code_q        <= code_d;
            valid_q       <= valid_d;
            any_pending_q <= any_pending_d;
        end
    end

    assign code        = code_q;
    assign valid       = valid_q;
    assign pending     = pending_q;
    assign any_pending = any_pending_q;

endmodule
